perft_line_formatter: RTL and testbench

Downstream stage of the hardware perft walker; it turns each per-root-move result and the final total into ASCII text.
- Per-move result (root move, subtree node count) emits one line, e.g. "e2e4: 20\n".
- Final total emits "\nNodes searched: N\n".
- Output is a byte stream with valid/ready, feeding the UART/host output FIFO.

---
 rtl/perft_fmt_pkg.sv | 50 +++++
 rtl/bin2bcd_seq.sv | 53 +++++
 rtl/perft_line_formatter.sv | 158 +++++++++++++++
 tb/tb_perft_line_formatter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/perft_fmt_pkg.sv
// rtl/perft_fmt_pkg.sv - shared types, constants and helpers for the perft line formatter
package perft_fmt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_PREFIX,
        ST_MOVE,
        ST_SEP,
        ST_DIGIT,
        ST_NL
    } fmt_state_t;

    localparam logic [2:0] PROMO_NONE = 3'd0;
    localparam logic [2:0] PROMO_N    = 3'd1;
    localparam logic [2:0] PROMO_B    = 3'd2;
    localparam logic [2:0] PROMO_R    = 3'd3;
    localparam logic [2:0] PROMO_Q    = 3'd4;

    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_NL    = 8'h0A;
    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h61;
    localparam logic [7:0] ASC_ONE   = 8'h31;

    // "\nNodes searched" - the ": " separator is shared with move lines
    localparam int PREFIX_LEN = 15;
    localparam logic [7:0] PREFIX_ROM [PREFIX_LEN] = '{
        8'h0A, "N", "o", "d", "e", "s", " ",
        "s", "e", "a", "r", "c", "h", "e", "d"
    };

    // ceil(node_w * log10(2)) in integer arithmetic (log10(2) ~= 0.30103)
    function automatic int calc_digits(input int node_w);
        return (node_w * 30103 + 99999) / 100000;
    endfunction

    // Promotion suffix letter; codes outside 1..4 have no suffix
    function automatic logic [7:0] promo_char(input logic [2:0] p);
        case (p)
            PROMO_N: return "n";
            PROMO_B: return "b";
            PROMO_R: return "r";
            PROMO_Q: return "q";
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble binary to BCD converter, one bit per cycle
module bin2bcd_seq #(
    parameter int NODE_W = 40,
    parameter int DIGITS = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NODE_W-1:0]     bin_in,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CNT_W = $clog2(NODE_W + 1);

    logic [NODE_W-1:0]   bin_sr;
    logic [CNT_W-1:0]    cnt;
    logic [4*DIGITS-1:0] bcd_adj;
    logic                adj_msb_unused;

    // Add 3 to every nibble >= 5 ahead of the shift
    always_comb begin
        bcd_adj = bcd_out;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_out[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_out[4*i +: 4] + 4'd3;
        end
    end

    // The top bit can never be set for a correctly sized DIGITS
    assign adj_msb_unused = bcd_adj[4*DIGITS-1];

    // Load consumes the first (always trivial) shift; remaining NODE_W-1 shifts follow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            bcd_out <= '0;
            cnt     <= '0;
            done    <= 1'b0;
        end else if (start) begin
            bin_sr  <= bin_in << 1;
            bcd_out <= {{(4*DIGITS-1){1'b0}}, bin_in[NODE_W-1]};
            cnt     <= CNT_W'(NODE_W - 1);
            done    <= (NODE_W == 1);
        end else if (cnt != '0) begin
            bin_sr  <= bin_sr << 1;
            bcd_out <= {bcd_adj[4*DIGITS-2:0], bin_sr[NODE_W-1]};
            cnt     <= cnt - CNT_W'(1);
            done    <= (cnt == CNT_W'(1));
        end
    end

endmodule

// File: rtl/perft_line_formatter.sv
// rtl/perft_line_formatter.sv - formats perft move results and totals as ASCII byte lines
module perft_line_formatter
    import perft_fmt_pkg::*;
#(
    parameter int NODE_W = 40,
    parameter int DIGITS = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_from,
    input  logic [5:0]        in_to,
    input  logic [2:0]        in_promo,
    input  logic [NODE_W-1:0] in_count,
    input  logic              in_is_total,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int IDX_W = $clog2((DIGITS > PREFIX_LEN) ? DIGITS : PREFIX_LEN);
    localparam logic [IDX_W-1:0] LAST_DIGIT  = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] LAST_PREFIX = IDX_W'(PREFIX_LEN - 1);

    generate
        if (DIGITS != calc_digits(NODE_W)) begin : g_bad_digits
            $error("DIGITS must equal ceil(NODE_W*log10(2))");
        end
    endgenerate

    fmt_state_t          state, nxt_state;
    logic [IDX_W-1:0]    idx, nxt_idx, dig_start, lz_start;
    logic [5:0]          from_sq, to_sq;
    logic [2:0]          promo;
    logic                is_total;
    logic [4*DIGITS-1:0] bcd;
    logic                conv_done, accept, fire, emit_nxt, has_promo;
    logic [3:0]          cur_digit;
    logic [7:0]          nxt_byte;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign has_promo = (promo >= PROMO_N) && (promo <= PROMO_Q);

    bin2bcd_seq #(.NODE_W(NODE_W), .DIGITS(DIGITS)) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept),
        .bin_in  (in_count),
        .done    (conv_done),
        .bcd_out (bcd)
    );

    // Count of leading zero digits, leaving at least one digit for a zero count
    always_comb begin
        lz_start = LAST_DIGIT;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                lz_start = IDX_W'(DIGITS - 1 - i);
        end
    end

    // Next state and byte index; emitting states only advance on a handshake
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        case (state)
            ST_IDLE:    if (accept) nxt_state = ST_CONVERT;
            ST_CONVERT: if (conv_done) begin
                nxt_state = is_total ? ST_PREFIX : ST_MOVE;
                nxt_idx   = '0;
            end
            ST_PREFIX:  if (fire) begin
                if (idx == LAST_PREFIX) begin nxt_state = ST_SEP; nxt_idx = '0; end
                else nxt_idx = idx + IDX_W'(1);
            end
            ST_MOVE:    if (fire) begin
                if (idx == (has_promo ? IDX_W'(4) : IDX_W'(3))) begin
                    nxt_state = ST_SEP;
                    nxt_idx   = '0;
                end else nxt_idx = idx + IDX_W'(1);
            end
            ST_SEP:     if (fire) begin
                if (idx == IDX_W'(1)) begin nxt_state = ST_DIGIT; nxt_idx = dig_start; end
                else nxt_idx = idx + IDX_W'(1);
            end
            ST_DIGIT:   if (fire) begin
                if (idx == LAST_DIGIT) nxt_state = ST_NL;
                else nxt_idx = idx + IDX_W'(1);
            end
            ST_NL:      if (fire) nxt_state = ST_IDLE;
            default:    nxt_state = ST_IDLE;
        endcase
    end

    // Byte for the next cycle; digit position counts from the most significant digit
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(DIGITS - 1 - i) == nxt_idx)
                cur_digit = bcd[4*i +: 4];
        end
        emit_nxt = 1'b1;
        nxt_byte = 8'h00;
        case (nxt_state)
            ST_PREFIX: nxt_byte = PREFIX_ROM[nxt_idx];
            ST_MOVE: begin
                case (nxt_idx)
                    IDX_W'(0): nxt_byte = ASC_A   + {5'd0, from_sq[2:0]};
                    IDX_W'(1): nxt_byte = ASC_ONE + {5'd0, from_sq[5:3]};
                    IDX_W'(2): nxt_byte = ASC_A   + {5'd0, to_sq[2:0]};
                    IDX_W'(3): nxt_byte = ASC_ONE + {5'd0, to_sq[5:3]};
                    default:   nxt_byte = promo_char(promo);
                endcase
            end
            ST_SEP:   nxt_byte = (nxt_idx == '0) ? ASC_COLON : ASC_SPACE;
            ST_DIGIT: nxt_byte = ASC_ZERO + {4'd0, cur_digit};
            ST_NL:    nxt_byte = ASC_NL;
            default:  emit_nxt = 1'b0;
        endcase
    end

    // FSM state, record capture and registered output byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            from_sq   <= '0;
            to_sq     <= '0;
            promo     <= PROMO_NONE;
            is_total  <= 1'b0;
            dig_start <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            if (accept) begin
                from_sq  <= in_from;
                to_sq    <= in_to;
                promo    <= in_promo;
                is_total <= in_is_total;
            end
            if (state == ST_CONVERT && conv_done)
                dig_start <= lz_start;
            out_valid <= emit_nxt;
            out_data  <= emit_nxt ? nxt_byte : 8'h00;
            out_last  <= (nxt_state == ST_NL);
        end
    end

endmodule

// File: tb/tb_perft_line_formatter.sv
// tb/tb_perft_line_formatter.sv - self-checking bench for perft_line_formatter
module tb_perft_line_formatter;

    localparam int NODE_W = 40;
    localparam int DIGITS = 13;
    localparam int NV     = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_from;
    logic [5:0]        in_to;
    logic [2:0]        in_promo;
    logic [NODE_W-1:0] in_count;
    logic              in_is_total;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    perft_line_formatter #(.NODE_W(NODE_W), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_from     (in_from),
        .in_to       (in_to),
        .in_promo    (in_promo),
        .in_count    (in_count),
        .in_is_total (in_is_total),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]        from;
        logic [5:0]        to;
        logic [2:0]        promo;
        logic [NODE_W-1:0] count;
        logic              is_total;
        bit                rnd_ready;
        bit                chk_lat;
        string             exp;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one record at a negedge; returns at the negedge after the accept edge
    task automatic drive_rec(input vec_t v, input bit hold);
        in_from     = v.from;
        in_to       = v.to;
        in_promo    = v.promo;
        in_count    = v.count;
        in_is_total = v.is_total;
        in_valid    = 1'b1;
        chk("in_ready_at_accept", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    // Gather output bytes and compare against exp; max_bytes=0 means the whole line
    task automatic collect(input string name, input string exp, input bit rnd,
                           input bit chk_lat, input int max_bytes);
        int         n          = 1;
        int         nb         = 0;
        int         first      = -1;
        bit         done       = 1'b0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_d     = 8'h00;
        logic       prev_l     = 1'b0;
        while (!done && n <= 400) begin
            if (prev_stall) begin
                chk({name, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
                chk({name, "_stall_data"}, {56'd0, out_data}, {56'd0, prev_d});
                chk({name, "_stall_last"}, {63'd0, out_last}, {63'd0, prev_l});
            end
            chk({name, "_in_ready_busy"}, {63'd0, in_ready}, 64'd0);
            out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (out_valid && first < 0) first = n;
            if (out_valid && out_ready) begin
                if (nb < exp.len()) begin
                    chk($sformatf("%s_byte%0d", name, nb), {56'd0, out_data}, {56'd0, exp[nb]});
                    chk($sformatf("%s_last%0d", name, nb), {63'd0, out_last},
                        {63'd0, (nb == exp.len() - 1)});
                end else begin
                    chk($sformatf("%s_extra_byte%0d", name, nb), {56'd0, out_data}, 64'd0);
                end
                nb++;
                if (out_last || (max_bytes != 0 && nb == max_bytes)) done = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk({name, "_timeout"}, 64'd1, 64'd0);
        end else if (max_bytes == 0) begin
            chk({name, "_byte_count"}, 64'(nb), 64'(exp.len()));
            chk({name, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
            chk({name, "_busy_after"}, {63'd0, busy}, 64'd0);
        end
        if (chk_lat && done) chk({name, "_latency"}, 64'(first), 64'(NODE_W + 1));
    endtask

    initial begin
        vecs[0] = '{6'd12, 6'd28, 3'd0, 40'd20, 1'b0, 1'b0, 1'b1, "e2e4: 20\n"};
        vecs[1] = '{6'd52, 6'd60, 3'd4, 40'd0, 1'b0, 1'b0, 1'b1, "e7e8q: 0\n"};
        vecs[2] = '{6'd52, 6'd60, 3'd6, 40'd0, 1'b0, 1'b0, 1'b0, "e7e8: 0\n"};
        vecs[3] = '{6'd0, 6'd0, 3'd0, 40'd8902, 1'b1, 1'b0, 1'b1, "\nNodes searched: 8902\n"};
        vecs[4] = '{6'd0, 6'd0, 3'd0, 40'hFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0,
                    "\nNodes searched: 1099511627775\n"};
        vecs[5] = '{6'd12, 6'd28, 3'd0, 40'd20, 1'b0, 1'b1, 1'b0, "e2e4: 20\n"};
        vecs[6] = '{6'd0, 6'd63, 3'd1, 40'd1000000, 1'b0, 1'b0, 1'b0, "a1h8n: 1000000\n"};
        vecs[7] = '{6'd7, 6'd56, 3'd2, 40'd5, 1'b0, 1'b1, 1'b0, "h1a8b: 5\n"};
        vecs[8] = '{6'd8, 6'd0, 3'd3, 40'd10, 1'b0, 1'b0, 1'b0, "a2a1r: 10\n"};
        vecs[9] = '{6'd5, 6'd5, 3'd0, 40'd0, 1'b1, 1'b1, 1'b0, "\nNodes searched: 0\n"};

        rst_n = 1'b0; in_valid = 1'b0; in_from = '0; in_to = '0; in_promo = '0;
        in_count = '0; in_is_total = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_data", {56'd0, out_data}, 64'd0);
        chk("reset_out_last", {63'd0, out_last}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            drive_rec(vecs[i], 1'b0);
            collect($sformatf("vec%0d", i), vecs[i].exp, vecs[i].rnd_ready, vecs[i].chk_lat, 0);
        end

        // Back-to-back: second record waits with in_valid held high
        drive_rec(vecs[0], 1'b1);
        in_from = 6'd52; in_to = 6'd60; in_promo = 3'd4; in_count = 40'd0; in_is_total = 1'b0;
        collect("b2b_first", "e2e4: 20\n", 1'b0, 1'b0, 0);
        chk("b2b_in_valid_held", {63'd0, in_valid}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_second_accepted", {63'd0, busy}, 64'd1);
        collect("b2b_second", "e7e8q: 0\n", 1'b0, 1'b1, 0);

        // Reset in the middle of a line
        drive_rec(vecs[0], 1'b0);
        collect("rst_partial", "e2e4: 20\n", 1'b0, 1'b0, 3);
        chk("rst_pre_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_async_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_async_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_release_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_release_busy", {63'd0, busy}, 64'd0);
        end
        drive_rec('{6'd6, 6'd21, 3'd0, 40'd9999999999, 1'b0, 1'b0, 1'b1, ""}, 1'b0);
        collect("after_rst", "g1f3: 9999999999\n", 1'b0, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
